// File: rtl/ascon_perm_arbiter.sv
// Round-robin arbiter/sequencer sharing one Ascon permutation core among four
// requesters: drives the state-mux select, issues start/rounds, returns ack.
module ascon_perm_arbiter #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned TW      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] rnd12,
  input  logic       perm_done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       perm_start,
  output logic [3:0] perm_rounds,
  output logic [3:0] ack,
  output logic       err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          perm_start_q, perm_start_d;
  logic [3:0]    perm_rounds_q, perm_rounds_d;
  logic [3:0]    ack_q, ack_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [1:0]    last_q, last_d;
  logic [TW-1:0] wd_q, wd_d;

  logic          pick_found;
  logic [1:0]    pick_idx;
  logic [1:0]    cand;
  logic          wd_expire;

  // Round-robin scan starting just after the last served requester
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'(last_q + 2'd1);
    cand       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = 2'(last_q + 2'(i + 1));
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign wd_expire = (TIMEOUT != 0) && (wd_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    gnt_d         = gnt_q;
    perm_start_d  = 1'b0;
    perm_rounds_d = 4'd0;
    ack_d         = 4'd0;
    err_d         = 1'b0;
    last_d        = last_q;
    wd_d          = wd_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d       = S_START;
          sel_d         = pick_idx;
          gnt_d         = 4'b0001 << pick_idx;
          perm_start_d  = 1'b1;
          perm_rounds_d = rnd12[pick_idx] ? 4'd12 : 4'd8;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes precedence over a same-cycle watchdog expiry
        if (perm_done) begin
          state_d = S_ACK;
          ack_d   = gnt_q;
        end else if (wd_expire) begin
          state_d = S_ACK;
          ack_d   = gnt_q;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end
      S_ACK: begin
        last_d  = sel_q;
        gnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sel_q         <= 2'd0;
      gnt_q         <= 4'd0;
      perm_start_q  <= 1'b0;
      perm_rounds_q <= 4'd0;
      ack_q         <= 4'd0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      last_q        <= 2'd3;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      gnt_q         <= gnt_d;
      perm_start_q  <= perm_start_d;
      perm_rounds_q <= perm_rounds_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      last_q        <= last_d;
      wd_q          <= wd_d;
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign perm_start  = perm_start_q;
  assign perm_rounds = perm_rounds_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// Scoreboard bench for ascon_perm_arbiter: stimulus predicts grant order and
// latency from round-robin rules; a monitor checks each start/ack it sees.
module tb_ascon_perm_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] rnd12;
  logic       perm_done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       perm_start;
  logic [3:0] perm_rounds;
  logic [3:0] ack;
  logic       err;
  logic       busy;

  logic done_m;
  logic spur;
  assign perm_done = done_m | spur;

  ascon_perm_arbiter #(.TIMEOUT(32), .TW(6)) dut (
    .clk(clk), .rst(rst), .req(req), .rnd12(rnd12), .perm_done(perm_done),
    .sel(sel), .gnt(gnt), .perm_start(perm_start), .perm_rounds(perm_rounds),
    .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int rounds;
    int err;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   dly_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   m_last = 3;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Core model: perm_done pulses d cycles after perm_start; d==0 means never
  int cd = 0;
  always @(negedge clk) begin
    done_m = 1'b0;
    if (rst) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) done_m = 1'b1;
      end
      if (perm_start) begin
        if (dly_q.size() == 0) begin
          chk("core_delay_avail", 0, 1);
          cd = 0;
        end else begin
          cd = dly_q.pop_front();
        end
      end
    end
  end

  // Monitor
  logic       in_op = 1'b0;
  logic [1:0] cap_sel;
  logic [3:0] cap_gnt;
  int         cap_rounds;
  int         cap_cyc;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_op = 1'b0;
    end else begin
      if (perm_start) begin
        in_op      = 1'b1;
        cap_sel    = sel;
        cap_gnt    = gnt;
        cap_rounds = int'(perm_rounds);
        cap_cyc    = cyc;
        chk("start_busy", int'(busy), 1);
        chk("start_gnt_onehot_sel", int'(gnt), int'(4'b0001 << sel));
      end else if (in_op) begin
        chk("gnt_sel_stable", int'({sel, gnt}), int'({cap_sel, cap_gnt}));
      end
      if (ack != 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", int'(ack), 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_onehot", int'(ack), 1 << e.idx);
          chk("ack_sel", int'(sel), e.idx);
          chk("ack_gnt", int'(gnt), 1 << e.idx);
          chk("rounds", cap_rounds, e.rounds);
          chk("ack_err", int'(err), e.err);
          chk("ack_latency", cyc - cap_cyc, e.lat);
        end
        in_op = 1'b0;
      end else if (err) begin
        chk("err_without_ack", 1, 0);
      end
    end
  end

  function automatic int pick(input int last, input logic [3:0] m);
    for (int i = 1; i <= 4; i++) begin
      if (m[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  function automatic int rand_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return 32;
    if (r == 2) return 1;
    return int'($urandom_range(1, 20));
  endfunction

  // One burst: raise mask; drop mode releases each req on its ack,
  // hold mode keeps mask for k grants then releases all.
  task automatic burst(input logic [3:0] mask, input logic [3:0] rnd,
                       input bit hold, input int k_in, input int fixed_d);
    logic [3:0] cur;
    int k, p, d, n, cnt;
    exp_t e;
    cur = mask;
    k = hold ? k_in : $countones(mask);
    for (int g = 0; g < k; g++) begin
      p = pick(m_last, cur);
      d = (fixed_d >= 0) ? fixed_d : rand_delay();
      e.idx = p;
      e.rounds = rnd[p] ? 12 : 8;
      e.err = (d == 0) ? 1 : 0;
      e.lat = (d == 0) ? 33 : d + 1;
      exp_q.push_back(e);
      dly_q.push_back(d);
      m_last = p;
      if (!hold) cur[p] = 1'b0;
    end
    @(negedge clk); #1;
    req = mask;
    rnd12 = rnd;
    @(negedge clk);
    chk("start_after_req", int'(perm_start), 1);
    n = 0;
    cnt = 0;
    while (n < k && cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (ack != 4'd0) begin
        n++;
        #1;
        if (hold) begin
          if (n == k) req = 4'd0;
        end else begin
          req = req & ~ack;
        end
      end
    end
    if (n < k) begin
      chk("burst_ack_count", n, k);
      req = 4'd0;
      exp_q.delete();
      dly_q.delete();
    end
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_gnt", int'(gnt), 0);
    // stray completion while idle must be ignored
    #1 spur = 1'b1;
    @(negedge clk); #1 spur = 1'b0;
    @(negedge clk);
    chk("spur_busy", int'(busy), 0);
  endtask

  initial begin
    int cnt;
    logic stray_ack;
    rst = 1'b1; req = 4'd0; rnd12 = 4'd0; spur = 1'b0; done_m = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_sel", int'(sel), 0);
      chk("rst_start", int'(perm_start), 0);
    end

    burst(4'b0100, 4'b0100, 1'b0, 0, 5);
    burst(4'b1111, 4'b1010, 1'b0, 0, -1);
    burst(4'b0010, 4'b0000, 1'b0, 0, -1);
    burst(4'b0011, 4'b0001, 1'b1, 4, -1);
    burst(4'b1000, 4'b1000, 1'b0, 0, 0);
    burst(4'b0001, 4'b0000, 1'b0, 0, 32);
    for (int b = 0; b < 30; b++) begin
      if ($urandom_range(0, 3) == 0)
        burst(4'($urandom_range(1, 15)), 4'($urandom), 1'b1, int'($urandom_range(2, 5)), -1);
      else
        burst(4'($urandom_range(1, 15)), 4'($urandom), 1'b0, 0, -1);
    end

    // Reset in WAIT
    burst(4'b0001, 4'b0001, 1'b0, 0, 3);
    @(negedge clk); #1;
    req = 4'b0010;
    rnd12 = 4'b0010;
    dly_q.push_back(0);
    cnt = 0;
    while (!perm_start && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("rstt_start_seen", int'(perm_start), 1);
    repeat (6) @(negedge clk);
    chk("rstt_wait_busy", int'(busy), 1);
    chk("rstt_wait_gnt", int'(gnt), 2);
    #1 rst = 1'b1; req = 4'd0;
    @(negedge clk);
    chk("rstt_sel", int'(sel), 0);
    chk("rstt_gnt", int'(gnt), 0);
    chk("rstt_start", int'(perm_start), 0);
    chk("rstt_rounds", int'(perm_rounds), 0);
    chk("rstt_ack", int'(ack), 0);
    chk("rstt_err", int'(err), 0);
    chk("rstt_busy", int'(busy), 0);
    #1 rst = 1'b0;
    m_last = 3;
    dly_q.delete();
    stray_ack = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ack != 4'd0) stray_ack = 1'b1;
    end
    chk("rstt_no_ack", int'(stray_ack), 0);
    burst(4'b1111, 4'b0110, 1'b0, 0, -1);
    burst(4'b0010, 4'b0010, 1'b0, 0, 4);

    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/ascon_perm_arbiter.md
Name: ascon_perm_arbiter

Overview:
Round-robin arbiter and sequencer that shares one Ascon permutation core between four requesters (e.g. init, AD, message, finalization engines). It drives the 2-bit select of the 4:1 state-input multiplexer in front of the core and issues the start/rounds command. It waits for core completion and returns a one-cycle acknowledge to the granted requester. A watchdog bounds each permutation.

Parameters:
TIMEOUT, 32, max cycles spent in WAIT before forced abort; 0 disables the watchdog
TW, 6, width of watchdog counter; must satisfy 2**TW > TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  per-requester request, level, held until ack
rnd12  input  4  per-requester round count: 1 = p12, 0 = p8; sampled at grant
perm_done  input  1  core completion pulse
sel  output  2  state-mux select, index of granted requester
gnt  output  4  one-hot grant, asserted START through ACK
perm_start  output  1  one-cycle core start pulse
perm_rounds  output  4  round count for core: 12 or 8, valid with perm_start
ack  output  4  one-hot, one-cycle completion pulse to granted requester
err  output  1  one-cycle pulse coincident with ack when watchdog aborted
busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, sel=0, gnt=0, perm_start=0, perm_rounds=0, ack=0, err=0, busy=0, last=3 (requester 0 has highest priority first), watchdog=0.
- FSM states: IDLE, START, WAIT, ACK. All outputs registered.
- IDLE: if req!=0, pick first set bit scanning (last+1) mod 4 upward with wrap; latch idx, sel<=idx, gnt<=onehot(idx), rounds<=rnd12[idx]?12:8; go START. req==0: stay; sel holds its last value.
- START (1 cycle): perm_start=1, perm_rounds valid; watchdog cleared; go WAIT.
- WAIT: perm_done=1 -> ACK. Else if TIMEOUT!=0 and watchdog==TIMEOUT-1 -> ACK with abort flag. Else watchdog++.
- ACK (1 cycle): ack[idx]=1, err=abort flag; last<=idx; gnt cleared on exit; go IDLE.
- Latency: grant decision to perm_start = 1 cycle (req seen in IDLE cycle n -> perm_start in cycle n+1). perm_done in cycle m -> ack in cycle m+1. Minimum occupancy per grant = 4 cycles incl. IDLE.
- sel and gnt are stable from START through ACK inclusive; the core's mux input never changes mid-permutation.
- perm_done is sampled only in WAIT; it is ignored in IDLE/START/ACK.
- req[idx] dropping during START/WAIT does not abort; the operation completes and ack still pulses.
- A requester still holding req in the IDLE cycle after its ack is eligible again but has lowest priority.
- perm_done and watchdog expiry in the same cycle: done wins, err=0.
- rst mid-operation returns everything to reset values next edge; no ack is issued; the core must be reset alongside.

Test Plan:
- Reset, req=4'b0000 for 10 cycles -> busy=0, gnt=0, sel=0, no perm_start.
- req=4'b0100, rnd12=4'b0100, perm_done 5 cycles after perm_start -> sel=2, gnt=4'b0100, perm_start 1 cycle after req, perm_rounds=12, ack=4'b0100 1 cycle after done, err=0.
- req=4'b1111 held, each req dropped on its ack -> grant order 0,1,2,3; sel sequence 0,1,2,3; each perm_rounds per rnd12.
- After grant to 1, req=4'b0011 held continuously -> next grant 0, then 1 (wrap-around fairness).
- TIMEOUT=32, perm_done never asserted -> ack and err pulse together 32 cycles after leaving START; next request then served normally.
- rst asserted in WAIT with gnt=4'b0010 -> next cycle all outputs at reset values, no ack; a later req=4'b0010 is granted normally.
